multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Parametrised multi-cycle control FSM for the 19-bit CPU; sequences FETCH/EXECUTE/MEMORY/WRITBK/CONTROL.
//  Adds over the previous generation: parametrised opcode width, a mem_ready wait-state handshake,
//  a memory timeout that traps to ERROR, an EXECUTE stall input, and a HALT opcode.
//  Sits between inst_reg (opcode source) and the datapath (ALU, regfile, PC mux, memory).
// PARAMETERS
//  OPW          5         opcode / ALU_op width
//  MEM_TIMEOUT  15        max consecutive not-ready cycles in FETCH/MEMORY before ERROR; 0 = timeout disabled
//  OP_LOAD      5'b01010  load opcode
//  OP_STORE     5'b01011  store opcode
//  OP_HALT      5'b11111  halt opcode
// PORTS
//  clk        in   1    system clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  opcode     in   OPW  opcode from inst_reg; stable from EXECUTE until the next FETCH
//  mem_ready  in   1    memory completed the access requested this cycle
//  stall      in   1    datapath hazard; holds EXECUTE
//  mem_read   out  1    memory read strobe
//  mem_write  out  1    memory write strobe
//  reg_write  out  1    register-file write enable
//  load_IR    out  1    inst_reg load enable
//  pc_enable  out  1    PC update enable
//  ALU_op     out  OPW  ALU operation select
//  pc_sel     out  2    PC source: 00 = +1, 01 = branch/jump, 10 = cond. branch, 11 = jump-reg
//  halted     out  1    FSM is in HALT
//  bus_err    out  1    FSM is in ERROR (memory timeout)
//  state_o    out  3    current state encoding, for debug
// BEHAVIOUR
//  State encoding: FETCH=0, EXECUTE=1, MEMORY=2, WRITBK=3, CONTROL=4, HALT=5, ERROR=6. Code 7 -> FETCH next cycle.
//  Reset: while rst_n=0, state=FETCH, wait_cnt=0 and every output is 0 (strobes gated by rst_n).
//  Outputs are combinational from state and opcode; any output not listed for a state is 0.
//  FETCH:   mem_read=1.
//           - mem_ready=1: also drive load_IR=1, pc_enable=1, pc_sel=00; next state EXECUTE.
//           - mem_ready=0: stay in FETCH.
//  EXECUTE: ALU_op=opcode.
//           - stall=1: stay in EXECUTE.
//           - otherwise: OP_HALT -> HALT; OP_LOAD/OP_STORE -> MEMORY;
//             {01101,01110,01111,10000,10001} -> CONTROL; any other opcode -> WRITBK.
//  MEMORY:  OP_LOAD drives mem_read=1; OP_STORE drives mem_write=1. The strobe is held until mem_ready=1.
//           - On ready: load -> WRITBK; store -> FETCH.
//  WRITBK:  reg_write=1 for one cycle; next state FETCH.
//  CONTROL: pc_enable=1 for one cycle; next state FETCH.
//           - pc_sel: 01101 or 10000 -> 01; 01110 or 01111 -> 10; 10001 -> 11.
//  HALT:    halted=1, all strobes 0. Sticky; exit only via rst_n.
//  ERROR:   bus_err=1, all strobes 0. Sticky; exit only via rst_n.
//  wait_cnt ($clog2(MEM_TIMEOUT+1) bits):
//           - Cleared on entry to FETCH/MEMORY and on any cycle with mem_ready=1.
//           - Increments each not-ready cycle in FETCH/MEMORY.
//           - Timeout: not-ready while wait_cnt==MEM_TIMEOUT-1 -> ERROR next cycle (MEM_TIMEOUT not-ready cycles).
//           - Saturates, never wraps. Ignored when MEM_TIMEOUT=0.
//  Simultaneous events:
//           - stall is ignored outside EXECUTE.
//           - mem_ready is ignored outside FETCH/MEMORY.
//           - mem_ready=1 on the timeout cycle wins: normal transition, no ERROR.
//  Latency (zero wait states): ALU op 3 cycles, load 4, store 3, control 3.
//           Each not-ready cycle or stall cycle adds 1.
//  Reset mid-operation: asynchronous. Strobes drop in the same cycle; restart in FETCH after release.
// TESTING
//  1. Reset, opcode=00001, mem_ready=1 -> states 0,1,3,0; ALU_op=00001 in EXECUTE; reg_write=1 only in WRITBK.
//  2. LOAD, mem_ready low 3 cycles in MEMORY -> mem_read high 4 cycles, then 1 reg_write cycle, back to FETCH.
//  3. STORE, mem_ready=1 -> mem_write high exactly 1 cycle, reg_write never asserted, FETCH next.
//  4. opcode=10001 -> CONTROL with pc_enable=1, pc_sel=11; 01110 -> pc_sel=10; 10000 -> pc_sel=01.
//  5. mem_ready held 0 in FETCH, MEMORY-timeout defaults -> ERROR after 15 cycles, bus_err=1, strobes 0 until rst_n.
//     Same with ready on the 15th cycle -> EXECUTE, no ERROR.
//  6. stall=1 for 2 cycles in EXECUTE adds 2 cycles. OP_HALT -> halted=1, sticky.
//     rst_n low mid-MEMORY -> mem_read drops immediately; FETCH after release.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// Handshake bundle between the multi-cycle control FSM and the datapath /
// instruction register / memory. The controller is the master: it consumes
// opcode, mem_ready and stall, and drives every strobe and status output.
interface multicycle_ctrl_fsm_if #(
    parameter int OPW = 5
);
    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           stall;
    logic           mem_read;
    logic           mem_write;
    logic           reg_write;
    logic           load_IR;
    logic           pc_enable;
    logic [OPW-1:0] ALU_op;
    logic [1:0]     pc_sel;
    logic           halted;
    logic           bus_err;
    logic [2:0]     state_o;

    modport master (
        input  opcode, mem_ready, stall,
        output mem_read, mem_write, reg_write, load_IR, pc_enable,
               ALU_op, pc_sel, halted, bus_err, state_o
    );

    modport slave (
        output opcode, mem_ready, stall,
        input  mem_read, mem_write, reg_write, load_IR, pc_enable,
               ALU_op, pc_sel, halted, bus_err, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM for the 19-bit CPU. Sequences FETCH / EXECUTE /
// MEMORY / WRITBK / CONTROL, waits on mem_ready with a timeout that traps to
// ERROR, holds EXECUTE on stall, and parks in HALT on the halt opcode.
module multicycle_ctrl_fsm #(
    parameter int             OPW         = 5,
    parameter int             MEM_TIMEOUT = 15,
    parameter logic [OPW-1:0] OP_LOAD     = OPW'(5'b01010),
    parameter logic [OPW-1:0] OP_STORE    = OPW'(5'b01011),
    parameter logic [OPW-1:0] OP_HALT     = OPW'(5'b11111)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_ctrl_fsm_if.master  bus
);
    // A zero timeout still needs a legal (1-bit) counter; it is simply never compared.
    localparam int WCW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WCW-1:0] TO_LAST = WCW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    // Control-transfer opcodes and the PC source each one selects.
    localparam logic [OPW-1:0] OP_C0 = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_C1 = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_C2 = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_C3 = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_C4 = OPW'(5'b10001);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_EXECUTE = 3'd1,
        S_MEMORY  = 3'd2,
        S_WRITBK  = 3'd3,
        S_CONTROL = 3'd4,
        S_HALT    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

    logic           mem_read_c, mem_write_c, reg_write_c, load_ir_c, pc_enable_c;
    logic           halted_c, bus_err_c;
    logic [OPW-1:0] alu_op_c;
    logic [1:0]     pc_sel_c;

    logic           is_load, is_store, is_ctrl, timeout_hit;
    logic [WCW-1:0] wait_inc;

    assign is_load     = (bus.opcode == OP_LOAD);
    assign is_store    = (bus.opcode == OP_STORE);
    assign is_ctrl     = (bus.opcode == OP_C0) || (bus.opcode == OP_C1) || (bus.opcode == OP_C2)
                      || (bus.opcode == OP_C3) || (bus.opcode == OP_C4);
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == TO_LAST);
    assign wait_inc    = (wait_cnt_q == {WCW{1'b1}}) ? wait_cnt_q : wait_cnt_q + 1'b1;

    // State and wait-counter registers; asynchronous reset parks in FETCH with a clear counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state, wait-counter and Moore/Mealy outputs; the counter clears on every
    // path except a not-ready cycle that stays in FETCH/MEMORY.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        load_ir_c   = 1'b0;
        pc_enable_c = 1'b0;
        halted_c    = 1'b0;
        bus_err_c   = 1'b0;
        alu_op_c    = '0;
        pc_sel_c    = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (bus.mem_ready) begin
                    load_ir_c   = 1'b1;
                    pc_enable_c = 1'b1;
                    state_d     = S_EXECUTE;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            S_EXECUTE: begin
                alu_op_c = bus.opcode;
                if (!bus.stall) begin
                    if (bus.opcode == OP_HALT)   state_d = S_HALT;
                    else if (is_load || is_store) state_d = S_MEMORY;
                    else if (is_ctrl)            state_d = S_CONTROL;
                    else                         state_d = S_WRITBK;
                end
            end
            S_MEMORY: begin
                mem_read_c  = is_load;
                mem_write_c = is_store;
                if (bus.mem_ready) begin
                    state_d = is_load ? S_WRITBK : S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            S_WRITBK: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_CONTROL: begin
                pc_enable_c = 1'b1;
                state_d     = S_FETCH;
                if ((bus.opcode == OP_C0) || (bus.opcode == OP_C3))      pc_sel_c = 2'b01;
                else if ((bus.opcode == OP_C1) || (bus.opcode == OP_C2)) pc_sel_c = 2'b10;
                else if (bus.opcode == OP_C4)                            pc_sel_c = 2'b11;
                else                                                     pc_sel_c = 2'b00;
            end
            S_HALT:  halted_c  = 1'b1;
            S_ERROR: bus_err_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    // Every output is forced low while reset is held, so strobes drop the moment rst_n falls.
    assign bus.mem_read  = mem_read_c  & rst_n;
    assign bus.mem_write = mem_write_c & rst_n;
    assign bus.reg_write = reg_write_c & rst_n;
    assign bus.load_IR   = load_ir_c   & rst_n;
    assign bus.pc_enable = pc_enable_c & rst_n;
    assign bus.halted    = halted_c    & rst_n;
    assign bus.bus_err   = bus_err_c   & rst_n;
    assign bus.ALU_op    = alu_op_c & {OPW{rst_n}};
    assign bus.pc_sel    = pc_sel_c & {2{rst_n}};
    assign bus.state_o   = state_q  & {3{rst_n}};
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed instruction sequences with literal
// per-cycle expectations, plus an instruction-level reference model compared
// against every DUT output on each falling clock edge.
module tb_multicycle_ctrl_fsm;
    localparam int TO = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    multicycle_ctrl_fsm_if #(.OPW(5)) bus ();

    multicycle_ctrl_fsm #(.OPW(5), .MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // PC source chosen by a control-transfer opcode; 0 means "not a control op".
    function automatic int pcsel_of(input logic [4:0] op);
        case (op)
            5'b01101, 5'b10000: return 1;
            5'b01110, 5'b01111: return 2;
            5'b10001:           return 3;
            default:            return 0;
        endcase
    endfunction

    // Reference model: phase of the current instruction plus the length of the current
    // unbroken run of not-ready memory cycles.
    int m_st   = 0;
    int m_miss = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st   = 0;
            m_miss = 0;
        end else begin
            case (m_st)
                0, 2: begin
                    if (bus.mem_ready) begin
                        m_miss = 0;
                        if (m_st == 0)                    m_st = 1;
                        else if (bus.opcode == 5'b01010)  m_st = 3;
                        else                              m_st = 0;
                    end else if (m_miss + 1 >= TO) begin
                        m_miss = 0;
                        m_st   = 6;
                    end else begin
                        m_miss = m_miss + 1;
                    end
                end
                1: if (!bus.stall) begin
                    if (bus.opcode == 5'b11111)                              m_st = 5;
                    else if (bus.opcode == 5'b01010 || bus.opcode == 5'b01011) m_st = 2;
                    else if (pcsel_of(bus.opcode) != 0)                      m_st = 4;
                    else                                                     m_st = 3;
                end
                5, 6:    m_st = m_st;
                default: m_st = 0;
            endcase
        end
    end

    // Compare every DUT output with the model on each falling edge.
    always @(negedge clk) begin
        int e_rd, e_wr, e_rw, e_ir, e_pc, e_alu, e_sel, e_h, e_e, e_st;
        e_st  = rst_n ? m_st : 0;
        e_rd  = rst_n && (m_st == 0 || (m_st == 2 && bus.opcode == 5'b01010));
        e_wr  = rst_n && (m_st == 2 && bus.opcode == 5'b01011);
        e_rw  = rst_n && (m_st == 3);
        e_ir  = rst_n && (m_st == 0) && bus.mem_ready;
        e_pc  = rst_n && (((m_st == 0) && bus.mem_ready) || m_st == 4);
        e_alu = (rst_n && m_st == 1) ? int'(bus.opcode) : 0;
        e_sel = (rst_n && m_st == 4) ? pcsel_of(bus.opcode) : 0;
        e_h   = rst_n && (m_st == 5);
        e_e   = rst_n && (m_st == 6);
        chk("mdl state_o",   bus.state_o,   e_st);
        chk("mdl mem_read",  bus.mem_read,  e_rd);
        chk("mdl mem_write", bus.mem_write, e_wr);
        chk("mdl reg_write", bus.reg_write, e_rw);
        chk("mdl load_IR",   bus.load_IR,   e_ir);
        chk("mdl pc_enable", bus.pc_enable, e_pc);
        chk("mdl ALU_op",    bus.ALU_op,    e_alu);
        chk("mdl pc_sel",    bus.pc_sel,    e_sel);
        chk("mdl halted",    bus.halted,    e_h);
        chk("mdl bus_err",   bus.bus_err,   e_e);
    end

    // One clock cycle with literal expectations. Strobes packed as
    // {mem_read,mem_write,reg_write,load_IR,pc_enable}; aux as {halted,bus_err,pc_sel,ALU_op}.
    task automatic run_cycle(input string nm, input logic rdy, input logic stl,
                             input int exp_st, input logic [4:0] exp_strb, input logic [8:0] exp_aux);
        bus.mem_ready = rdy;
        bus.stall     = stl;
        @(negedge clk);
        chk({nm, " state"},   bus.state_o, exp_st);
        chk({nm, " strobes"}, {bus.mem_read, bus.mem_write, bus.reg_write, bus.load_IR, bus.pc_enable}, exp_strb);
        chk({nm, " aux"},     {bus.halted, bus.bus_err, bus.pc_sel, bus.ALU_op}, exp_aux);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst strobes", {bus.mem_read, bus.mem_write, bus.reg_write, bus.load_IR, bus.pc_enable}, 0);
        chk("rst aux", {bus.halted, bus.bus_err, bus.pc_sel, bus.ALU_op}, 0);
        chk("rst state", bus.state_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode    = 5'b00000;
        bus.mem_ready = 1'b1;
        bus.stall     = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // ALU instruction, zero wait states
        bus.opcode = 5'b00001;
        run_cycle("t1 fetch", 1, 0, 0, 5'b10011, 9'b0);
        run_cycle("t1 exec",  1, 0, 1, 5'b00000, {4'b0000, 5'b00001});
        run_cycle("t1 wb",    1, 0, 3, 5'b00100, 9'b0);

        // Load with three memory wait states
        bus.opcode = 5'b01010;
        run_cycle("t2 fetch", 1, 0, 1 - 1, 5'b10011, 9'b0);
        run_cycle("t2 exec",  0, 0, 1, 5'b00000, {4'b0000, 5'b01010});
        for (int i = 0; i < 3; i++) run_cycle("t2 mem wait", 0, 0, 2, 5'b10000, 9'b0);
        run_cycle("t2 mem rdy", 1, 0, 2, 5'b10000, 9'b0);
        run_cycle("t2 wb",      1, 0, 3, 5'b00100, 9'b0);

        // Store, zero wait states
        bus.opcode = 5'b01011;
        run_cycle("t3 fetch", 1, 0, 0, 5'b10011, 9'b0);
        run_cycle("t3 exec",  1, 0, 1, 5'b00000, {4'b0000, 5'b01011});
        run_cycle("t3 mem",   1, 0, 2, 5'b01000, 9'b0);

        // Control transfers and their PC source
        bus.opcode = 5'b10001;
        run_cycle("t4a fetch", 1, 0, 0, 5'b10011, 9'b0);
        run_cycle("t4a exec",  1, 0, 1, 5'b00000, {4'b0000, 5'b10001});
        run_cycle("t4a ctrl",  1, 0, 4, 5'b00001, 9'b001100000);
        bus.opcode = 5'b01110;
        run_cycle("t4b fetch", 1, 0, 0, 5'b10011, 9'b0);
        run_cycle("t4b exec",  1, 0, 1, 5'b00000, {4'b0000, 5'b01110});
        run_cycle("t4b ctrl",  1, 0, 4, 5'b00001, 9'b001000000);
        bus.opcode = 5'b10000;
        run_cycle("t4c fetch", 1, 0, 0, 5'b10011, 9'b0);
        run_cycle("t4c exec",  1, 0, 1, 5'b00000, {4'b0000, 5'b10000});
        run_cycle("t4c ctrl",  1, 0, 4, 5'b00001, 9'b000100000);

        // Two stall cycles in EXECUTE; stall ignored in WRITBK
        bus.opcode = 5'b00010;
        run_cycle("t6 fetch",   1, 0, 0, 5'b10011, 9'b0);
        run_cycle("t6 stall1",  0, 1, 1, 5'b00000, {4'b0000, 5'b00010});
        run_cycle("t6 stall2",  1, 1, 1, 5'b00000, {4'b0000, 5'b00010});
        run_cycle("t6 exec",    1, 0, 1, 5'b00000, {4'b0000, 5'b00010});
        run_cycle("t6 wb",      1, 1, 3, 5'b00100, 9'b0);

        // Ready arrives on the 15th fetch cycle: no trap
        bus.opcode = 5'b00011;
        for (int i = 0; i < TO - 1; i++) run_cycle("t5b fetch wait", 0, 0, 0, 5'b10000, 9'b0);
        run_cycle("t5b fetch rdy", 1, 0, 0, 5'b10011, 9'b0);
        run_cycle("t5b exec",      1, 0, 1, 5'b00000, {4'b0000, 5'b00011});
        run_cycle("t5b wb",        1, 0, 3, 5'b00100, 9'b0);

        // Fetch never ready: ERROR after 15 cycles, sticky
        for (int i = 0; i < TO; i++) run_cycle("t5a fetch wait", 0, 0, 0, 5'b10000, 9'b0);
        for (int i = 0; i < 3; i++)  run_cycle("t5a error", 1, 0, 6, 5'b00000, 9'b010000000);
        do_reset();

        // HALT is sticky
        bus.opcode = 5'b11111;
        run_cycle("t6h fetch", 1, 0, 0, 5'b10011, 9'b0);
        run_cycle("t6h exec",  1, 0, 1, 5'b00000, {4'b0000, 5'b11111});
        for (int i = 0; i < 3; i++) run_cycle("t6h halt", 1, 0, 5, 5'b00000, 9'b100000000);
        do_reset();

        // Reset in the middle of a load's memory phase
        bus.opcode = 5'b01010;
        run_cycle("t6r fetch", 1, 0, 0, 5'b10011, 9'b0);
        run_cycle("t6r exec",  1, 0, 1, 5'b00000, {4'b0000, 5'b01010});
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("t6r mem_read before rst", bus.mem_read, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6r mem_read in rst", bus.mem_read, 0);
        chk("t6r state in rst", bus.state_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle("t6r refetch", 1, 0, 0, 5'b10011, 9'b0);
        run_cycle("t6r reexec",  1, 0, 1, 5'b00000, {4'b0000, 5'b01010});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
